// File: rtl/ee354_dirn_queue_if.sv
// Command/status bundle between the button front end and the snake direction queue.
interface ee354_dirn_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned DW = $clog2(DEPTH) + 1;

    logic          Cmd_Valid;
    logic [1:0]    Cmd_Dirn;
    logic [1:0]    Cur_Dirn;
    logic          Step_Pulse;
    logic [DW-1:0] Depth;
    logic          Overflow;
    logic [7:0]    Drop_Cnt;

    modport master (
        output Cmd_Valid, Cmd_Dirn,
        input  Cur_Dirn, Step_Pulse, Depth, Overflow, Drop_Cnt
    );

    modport slave (
        input  Cmd_Valid, Cmd_Dirn,
        output Cur_Dirn, Step_Pulse, Depth, Overflow, Drop_Cnt
    );
endinterface

// File: rtl/ee354_dirn_queue.sv
// Snake direction command queue: filters illegal turns, buffers legal ones and
// applies one per synchronized speed tick.
module ee354_dirn_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic             board_clk,
    input  logic             Reset,
    input  logic             Step_Tick,
    input  logic             Run,
    ee354_dirn_queue_if.slave q
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned DW = AW + 1;

    logic          sync1, sync2, hist;
    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
    logic [DW-1:0] depth, depth_nxt;
    logic [1:0]    cur_dirn, cur_dirn_nxt;
    logic          step_pulse, step_pulse_nxt;
    logic          overflow, overflow_nxt;
    logic [7:0]    drop_cnt, drop_cnt_nxt;

    logic          step_evt_c, empty_c, full_c, legal_c;
    logic          pop_evt_c, pop_c, push_c, drop_c;
    logic [AW-1:0] tail_idx_c;
    logic [1:0]    ref_dirn_c;

    // Step_Tick is asynchronous: two-flop synchronizer plus edge-detect history
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= Step_Tick;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign step_evt_c = sync2 & ~hist;
    assign empty_c    = (depth == '0);
    assign full_c     = (depth == DW'(DEPTH));
    assign tail_idx_c = wr_ptr - AW'(1);
    assign ref_dirn_c = empty_c ? cur_dirn : mem[tail_idx_c];

    // Same axis (equal or reverse) shares bit1, so only a bit1 change is a legal turn
    assign legal_c   = q.Cmd_Valid & (q.Cmd_Dirn[1] != ref_dirn_c[1]);
    assign pop_evt_c = Run & step_evt_c;
    assign pop_c     = pop_evt_c & ~empty_c;
    assign push_c    = Run & legal_c & (~full_c | pop_evt_c);
    assign drop_c    = Run & legal_c & full_c & ~pop_evt_c;

    always_comb begin
        rd_ptr_nxt     = rd_ptr;
        wr_ptr_nxt     = wr_ptr;
        depth_nxt      = depth;
        cur_dirn_nxt   = cur_dirn;
        step_pulse_nxt = 1'b0;
        overflow_nxt   = overflow | drop_c;
        drop_cnt_nxt   = drop_cnt;

        if (drop_c && (drop_cnt != 8'hFF)) begin
            drop_cnt_nxt = drop_cnt + 8'd1;
        end

        if (!Run) begin
            rd_ptr_nxt   = '0;
            wr_ptr_nxt   = '0;
            depth_nxt    = '0;
            cur_dirn_nxt = 2'b11;
        end else begin
            step_pulse_nxt = step_evt_c;
            if (pop_c) begin
                cur_dirn_nxt = mem[rd_ptr];
                rd_ptr_nxt   = rd_ptr + AW'(1);
            end
            if (push_c) begin
                wr_ptr_nxt = wr_ptr + AW'(1);
            end
            depth_nxt = depth + DW'(push_c) - DW'(pop_c);
        end
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            depth      <= '0;
            cur_dirn   <= 2'b11;
            step_pulse <= 1'b0;
            overflow   <= 1'b0;
            drop_cnt   <= 8'd0;
        end else begin
            rd_ptr     <= rd_ptr_nxt;
            wr_ptr     <= wr_ptr_nxt;
            depth      <= depth_nxt;
            cur_dirn   <= cur_dirn_nxt;
            step_pulse <= step_pulse_nxt;
            overflow   <= overflow_nxt;
            drop_cnt   <= drop_cnt_nxt;
        end
    end

    // Storage needs no reset: occupancy is tracked by depth and the pointers
    always_ff @(posedge board_clk) begin
        if (push_c) begin
            mem[wr_ptr] <= q.Cmd_Dirn;
        end
    end

    assign q.Cur_Dirn   = cur_dirn;
    assign q.Step_Pulse = step_pulse;
    assign q.Depth      = depth;
    assign q.Overflow   = overflow;
    assign q.Drop_Cnt   = drop_cnt;
endmodule
